// File: rtl/data_ram_resp_pkg.sv
// Shared types and helpers for the data_ram_resp load/store responder.
package data_ram_resp_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Counter preload for WAIT; a zero wait configuration bypasses WAIT entirely.
    function automatic logic [3:0] wait_load(input int wait_cycles);
        return (wait_cycles > 0) ? 4'(wait_cycles - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// Request/response handshake bundle between the memory stage and data_ram_resp.
interface data_ram_resp_if;
    import data_ram_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr_en;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wr_data;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rd_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr_en, req_addr, req_wr_data, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_err
    );

    modport slave (
        input  req_valid, req_wr_en, req_addr, req_wr_data, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rd_data, rsp_err
    );

endinterface

// File: rtl/data_ram_resp_ram_1p.sv
// Single-port DEPTH x 32 storage array: synchronous read, per-byte write enables.
module ram_1p
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately never reset; only lanes with a set strobe change.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-before-write: the output register captures the old word on a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_resp.sv
// Load/store responder: valid/ready request, fixed wait states, registered response.
// Optional out-of-range detection is enabled by defining DATA_RAM_RANGE_CHECK_EN.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    data_ram_resp_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              wr_en_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              oor_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              addr_oor;
    logic              unused_addr;

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign addr_oor    = |bus.req_addr[31:AW+2];
    assign unused_addr = ^bus.req_addr[1:0];
`else
    assign addr_oor    = 1'b0;
    assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            wr_en_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            oor_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_en_q     <= bus.req_wr_en;
                        idx_q       <= bus.req_addr[AW+1:2];
                        wdata_q     <= bus.req_wr_data;
                        wstrb_q     <= bus.req_wstrb;
                        oor_q       <= addr_oor;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= oor_q;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The array is touched only in ACCESS; out-of-range writes are suppressed there.
    ram_1p #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_ACCESS),
        .we    (wr_en_q && !oor_q),
        .wstrb (wstrb_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rd_data = ram_rdata & {DATA_W{~rsp_err_q}};

endmodule
